// File: rtl/ascon_pkg.sv
// ascon_pkg: shared constants and types for the ASCON block scheduler
package ascon_pkg;
  localparam int WBLK_C = 64;
  localparam int NBLOCKS_C = 23;
  localparam int CNT_W_C = $clog2(NBLOCKS_C);
  typedef enum logic [3:0] {IDLE, INIT, INIT_W, AD, AD_W, SEND, RECV, TAG_W, DONE} sched_state_t;
  typedef logic [WBLK_C-1:0] blk_t;
endpackage

// File: rtl/ascon_blk_slicer.sv
// ascon_blk_slicer: combinational MSB-first selection of block idx from a wave
module ascon_blk_slicer
  import ascon_pkg::*;
#(
  parameter int NBLOCKS = NBLOCKS_C,
  parameter int WBLK = WBLK_C,
  parameter int CW = CNT_W_C
) (
  input  logic [NBLOCKS*WBLK-1:0] wave,
  input  logic [CW-1:0]           idx,
  output logic [WBLK-1:0]         blk
);
  // block 0 sits in the top WBLK bits, so shift the wanted block down to bit 0
  assign blk = WBLK'(wave >> (WBLK * (NBLOCKS - 1 - int'(idx))));
endmodule

// File: rtl/ascon_block_sched.sv
// ascon_block_sched: drives the ASCON core through init, AD and 23 block round trips; optional watchdog via ASCON_SCHED_TIMEOUT_EN
module ascon_block_sched
  import ascon_pkg::*;
#(
  parameter int NBLOCKS = NBLOCKS_C,
  parameter int WBLK = WBLK_C,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic [NBLOCKS*WBLK-1:0] wave_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    init_o,
  input  logic                    init_done_i,
  output logic                    ad_o,
  input  logic                    ad_done_i,
  output logic [WBLK-1:0]         blk_o,
  output logic                    blk_valid_o,
  output logic                    blk_last_o,
  input  logic                    blk_ready_i,
  input  logic [WBLK-1:0]         cph_i,
  input  logic                    cph_valid_i,
  input  logic                    tag_valid_i,
  output logic [NBLOCKS*WBLK-1:0] cipher_o
);
  localparam int CW = NBLOCKS > 1 ? $clog2(NBLOCKS) : 1;
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("ascon_block_sched: TIMEOUT must be at least 2");
  end
  sched_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [NBLOCKS*WBLK-1:0] wave_q;
  logic [WBLK-1:0] slot [NBLOCKS];
  logic last, wr, accept, tmo;
  assign last = cnt == CW'(NBLOCKS - 1);
  assign wr = state == RECV && cph_valid_i;
  assign accept = state == IDLE && start_i;
  assign init_o = state == INIT;
  assign ad_o = state == AD;
  assign blk_valid_o = state == SEND;
  assign blk_last_o = state == SEND && last;
  assign done_o = state == DONE;
  assign busy_o = state != IDLE && state != DONE;
  ascon_blk_slicer #(.NBLOCKS(NBLOCKS), .WBLK(WBLK), .CW(CW)) u_slicer (
    .wave(wave_q),
    .idx(cnt),
    .blk(blk_o)
  );
`ifdef ASCON_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT);
  logic [TW-1:0] tcnt;
  logic waiting, err_q;
  assign waiting = state inside {INIT_W, AD_W, SEND, RECV, TAG_W};
  assign tmo = waiting && tcnt == TW'(TIMEOUT - 1);
  assign err_o = err_q;
  // per-state watchdog; restarts on every state change, sticky error until next start
  always_ff @(posedge clock_i) begin
    tcnt <= (reset_i || state_n != state || !waiting) ? '0 : tcnt + 1'b1;
    err_q <= (reset_i || accept) ? 1'b0 : (tmo && state_n == IDLE) ? 1'b1 : err_q;
  end
`else
  assign tmo = 1'b0;
  assign err_o = 1'b0;
`endif
  // state register
  always_ff @(posedge clock_i) begin
    state <= reset_i ? IDLE : state_n;
  end
  // next-state logic; a watchdog expiry overrides any wait that made no progress
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = start_i ? INIT : IDLE;
      INIT:    state_n = INIT_W;
      INIT_W:  state_n = init_done_i ? AD : INIT_W;
      AD:      state_n = AD_W;
      AD_W:    state_n = ad_done_i ? SEND : AD_W;
      SEND:    state_n = blk_ready_i ? RECV : SEND;
      RECV:    state_n = cph_valid_i ? (last ? TAG_W : SEND) : RECV;
      TAG_W:   state_n = tag_valid_i ? DONE : TAG_W;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (tmo && state_n == state) state_n = IDLE;
  end
  // wave latch and block counter; the counter stops at the last block
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt <= '0;
      wave_q <= '0;
    end else if (accept) begin
      cnt <= '0;
      wave_q <= wave_i;
    end else if (wr && !last) begin
      cnt <= cnt + 1'b1;
    end
  end
  // cipher collection; slots persist across runs and are only overwritten
  always_ff @(posedge clock_i) begin
    for (int i = 0; i < NBLOCKS; i++) slot[i] <= reset_i ? '0 : (wr && cnt == CW'(i)) ? cph_i : slot[i];
  end
  for (genvar k = 0; k < NBLOCKS; k++) begin : g_pack
    assign cipher_o[(NBLOCKS-k)*WBLK-1 -: WBLK] = slot[k];
  end
endmodule

// File: tb/tb_ascon_block_sched.sv
// tb_ascon_block_sched: randomized directed bench with a behavioural core and cipher model
module tb_ascon_block_sched;
  localparam int N = 23;
  localparam int W = 64;
  localparam int WW = N * W;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [WW-1:0] wave = '0;
  logic busy, done, err, init, ad, blk_valid, blk_last;
  logic init_done = 1'b0;
  logic ad_done = 1'b0;
  logic blk_ready = 1'b0;
  logic cph_valid = 1'b0;
  logic tag_valid = 1'b0;
  logic [W-1:0] cph = '0;
  logic [W-1:0] blk;
  logic [WW-1:0] cipher;
  logic [WW-1:0] model_cipher = '0;
  int checks = 0;
  int failures = 0;

  ascon_block_sched #(.TIMEOUT(16)) dut (
    .clock_i(clk), .reset_i(rst), .start_i(start), .wave_i(wave),
    .busy_o(busy), .done_o(done), .err_o(err),
    .init_o(init), .init_done_i(init_done), .ad_o(ad), .ad_done_i(ad_done),
    .blk_o(blk), .blk_valid_o(blk_valid), .blk_last_o(blk_last), .blk_ready_i(blk_ready),
    .cph_i(cph), .cph_valid_i(cph_valid), .tag_valid_i(tag_valid), .cipher_o(cipher)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] slice(input logic [WW-1:0] v, input int k);
    return v[WW-1-k*W -: W];
  endfunction

  function automatic logic [WW-1:0] rnd_wave();
    logic [WW-1:0] v;
    for (int k = 0; k < N; k++) v[WW-1-k*W -: W] = {$urandom, $urandom};
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cipher(input string tag);
    for (int k = 0; k < N; k++) chk($sformatf("%s[%0d]", tag, k), slice(cipher, k), slice(model_cipher, k));
  endtask

  task automatic spurious(input bit on);
    init_done = on; ad_done = on; blk_ready = on; cph_valid = on; tag_valid = on;
    cph = {$urandom, $urandom};
  endtask

  task automatic run(input logic [WW-1:0] w, input logic [W-1:0] m, input int bp_blk, input int bp_n,
                     input int busy_blk, input int rst_blk, input bit spur);
    logic [W-1:0] b;
    start = 1'b1; wave = w;
    step();
    start = 1'b0; wave = ~w;
    chk("init_pulse", init, 1'b1);
    chk("busy_after_start", busy, 1'b1);
    step();
    chk("init_single", init, 1'b0);
    repeat ($urandom_range(0, 3)) begin
      cph_valid = spur; tag_valid = spur; ad_done = spur;
      cph = {$urandom, $urandom};
      step();
      chk("init_w_no_ad", ad, 1'b0);
      chk("init_w_no_blk", blk_valid, 1'b0);
    end
    spurious(1'b0);
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    chk("ad_pulse", ad, 1'b1);
    step();
    chk("ad_single", ad, 1'b0);
    repeat ($urandom_range(0, 3)) begin
      init_done = spur; blk_ready = spur; cph_valid = spur; tag_valid = spur;
      step();
      chk("ad_w_no_blk", blk_valid, 1'b0);
    end
    spurious(1'b0);
    ad_done = 1'b1;
    step();
    ad_done = 1'b0;
    for (int k = 0; k < N; k++) begin
      b = slice(w, k);
      chk("blk_valid", blk_valid, 1'b1);
      chk("blk_data", blk, b);
      chk("blk_last", blk_last, (k == N - 1));
      if (k == bp_blk) begin
        repeat (bp_n) begin
          tag_valid = spur; cph_valid = spur; cph = {$urandom, $urandom};
          step();
          chk("bp_valid", blk_valid, 1'b1);
          chk("bp_data", blk, b);
          chk("bp_no_write", slice(cipher, k), slice(model_cipher, k));
          chk("bp_no_done", done, 1'b0);
        end
        tag_valid = 1'b0; cph_valid = 1'b0;
      end
      blk_ready = 1'b1;
      if (spur && k == 3) begin
        cph_valid = 1'b1; cph = ~(b ^ m);
      end
      step();
      blk_ready = 1'b0; cph_valid = 1'b0;
      chk("recv_no_valid", blk_valid, 1'b0);
      chk("send_cph_ignored", slice(cipher, k), slice(model_cipher, k));
      if (k == rst_blk) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_cipher = '0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", blk_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_init", init, 1'b0);
        chk("rst_err", err, 1'b0);
        check_cipher("rst_cipher");
        return;
      end
      if (k == busy_blk) begin
        start = 1'b1; wave = rnd_wave();
        step();
        start = 1'b0;
        chk("busy_start_ignored", busy, 1'b1);
        chk("busy_no_reinit", init, 1'b0);
      end
      repeat ($urandom_range(0, 2)) step();
      cph_valid = 1'b1; cph = b ^ m;
      step();
      cph_valid = 1'b0;
      model_cipher[WW-1-k*W -: W] = b ^ m;
    end
    check_cipher("cipher_pre_tag");
    repeat ($urandom_range(0, 3)) begin
      blk_ready = spur; cph_valid = spur; cph = {$urandom, $urandom};
      step();
      chk("tag_w_no_done", done, 1'b0);
      chk("tag_w_busy", busy, 1'b1);
    end
    spurious(1'b0);
    tag_valid = 1'b1;
    step();
    tag_valid = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("done_busy_low", busy, 1'b0);
    chk("done_err", err, 1'b0);
    check_cipher("cipher_done");
    step();
    chk("done_single", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    repeat (3) step();
    check_cipher("cipher_hold");
  endtask

  initial begin
    logic [WW-1:0] w;
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_err", err, 1'b0);
    chk("reset_init", init, 1'b0);
    chk("reset_ad", ad, 1'b0);
    chk("reset_valid", blk_valid, 1'b0);
    chk("reset_last", blk_last, 1'b0);
    chk("reset_blk", blk, 64'h0);
    check_cipher("reset_cipher");
    for (int k = 0; k < N; k++) w[WW-1-k*W -: W] = W'(k);
    run(w, '1, -1, 0, -1, -1, 1'b0);
    run(rnd_wave(), {$urandom, $urandom}, 7, 5, 10, -1, 1'b0);
    run(rnd_wave(), {$urandom, $urandom}, -1, 0, -1, 12, 1'b0);
    run(rnd_wave(), {$urandom, $urandom}, 4, 3, -1, -1, 1'b1);
    run(rnd_wave(), {$urandom, $urandom}, int'($urandom_range(0, N - 1)), 2, 5, -1, 1'b1);
`ifdef ASCON_SCHED_TIMEOUT_EN
    start = 1'b1; wave = rnd_wave();
    step();
    start = 1'b0;
    step();
    init_done = 1'b1;
    step();
    init_done = 1'b0;
    step();
    for (int c = 1; c <= 16; c++) begin
      chk($sformatf("tmo_err_low[%0d]", c), err, 1'b0);
      chk($sformatf("tmo_busy[%0d]", c), busy, 1'b1);
      chk($sformatf("tmo_no_done[%0d]", c), done, 1'b0);
      if (c < 16) step();
    end
    step();
    chk("tmo_err_set", err, 1'b1);
    chk("tmo_busy_low", busy, 1'b0);
    chk("tmo_no_done", done, 1'b0);
    repeat (3) step();
    chk("tmo_err_sticky", err, 1'b1);
    chk("tmo_no_done_idle", done, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("tmo_err_cleared", err, 1'b0);
    chk("tmo_restart_busy", busy, 1'b1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ascon_block_sched.md
Name: ascon_block_sched

Overview:
Sequencer between the UART command FSM and the ASCON core. On start, it drives the core through initialisation and associated-data absorption. It then feeds the 1472-bit plaintext wave as 23 x 64-bit blocks, one outstanding at a time, and collects each 64-bit cipher block into a 1472-bit output register. It waits for the tag and pulses done; that pulse is the "cipher ready" strobe for the UART FSM.

Parameters:
NBLOCKS, 23, number of 64-bit blocks per wave (wave width = NBLOCKS*WBLK)
WBLK, 64, block width in bits
TIMEOUT, 1024, watchdog limit in cycles per wait state (used only with the optional feature)

Ports:
clock_i  in  1  system clock (50 MHz domain)
reset_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle start request from the UART FSM
wave_i  in  NBLOCKS*WBLK  plaintext wave, sampled on an accepted start
busy_o  out  1  high from accepted start until done_o
done_o  out  1  one-cycle pulse when cipher_o and the tag are valid
err_o  out  1  sticky watchdog error; constant 0 without the optional feature
init_o  out  1  one-cycle pulse: core loads key/nonce and permutes
init_done_i  in  1  core finished initialisation
ad_o  out  1  one-cycle pulse: core absorbs associated data
ad_done_i  in  1  core finished associated-data phase
blk_o  out  WBLK  current plaintext block
blk_valid_o  out  1  blk_o valid; held until blk_ready_i
blk_last_o  out  1  high with blk_valid_o on block NBLOCKS-1
blk_ready_i  in  1  core accepts blk_o this cycle
cph_i  in  WBLK  cipher block from core
cph_valid_i  in  1  cph_i valid, one cycle
tag_valid_i  in  1  core tag valid after finalisation
cipher_o  out  NBLOCKS*WBLK  collected ciphertext register

Behaviour:
- Reset is synchronous and active-high, applied on the rising clock_i edge. Reset values: state IDLE, block counter 0, wave register 0, cipher_o 0, err_o 0, and every output strobe/valid 0.
- Block order is MSB-first: block k = wave bits [NBLOCKS*WBLK-1-k*WBLK -: WBLK]. Cipher block k is written to the same slice of cipher_o.
- Counter width = $clog2(NBLOCKS), 5 bits for 23. It counts 0..NBLOCKS-1 and never wraps; it is cleared on entry to INIT.
- States and transitions:
  - IDLE: if start_i=1, latch wave_i, set busy_o, go to INIT. Otherwise stay.
  - INIT: pulse init_o for 1 cycle, then go to INIT_W.
  - INIT_W: when init_done_i=1, go to AD.
  - AD: pulse ad_o for 1 cycle, then go to AD_W.
  - AD_W: when ad_done_i=1, go to SEND.
  - SEND: assert blk_valid_o with blk_o = block[cnt], blk_last_o = (cnt==NBLOCKS-1). When blk_ready_i=1 in the same cycle, go to RECV.
  - RECV: blk_valid_o=0. When cph_valid_i=1, write cph_i into slot cnt. Then, if cnt==NBLOCKS-1, go to TAG_W; else cnt+1 and go to SEND.
  - TAG_W: when tag_valid_i=1, go to DONE.
  - DONE: done_o=1 for 1 cycle, busy_o drops, go to IDLE.
- Latency: start_i to init_o is 1 cycle. cph_valid_i on the last block to done_o is 1 cycle after tag_valid_i is seen.
- blk_o and blk_valid_o must stay stable while blk_valid_o=1 and blk_ready_i=0.
- start_i while busy_o=1 is ignored; wave_i is not resampled.
- Done strobes (init_done_i, ad_done_i, cph_valid_i, tag_valid_i) arriving in a state that does not wait for them are ignored.
- cph_valid_i and blk_ready_i arriving in the same SEND cycle: cph_valid_i is ignored, since no block is outstanding yet.
- cipher_o holds its value after done_o until the next accepted start. Slots are then overwritten progressively; they are not cleared.
- reset_i mid-operation aborts immediately to IDLE with all reset values.

Optional Feature:
- Macro: ASCON_SCHED_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in INIT_W, AD_W, SEND, RECV and TAG_W. It is cleared on every state change.
  - Reaching TIMEOUT sets err_o (sticky) and forces IDLE with busy_o=0; done_o is not pulsed.
  - err_o clears only on reset_i or on the next accepted start_i.
- Without the macro: no counter logic is generated, err_o is tied 0, and wait states wait forever.

Decomposition:
- Package ascon_pkg holds:
  - WBLK_C=64, NBLOCKS_C=23 and CNT_W_C=$clog2(NBLOCKS_C).
  - typedef enum logic [3:0] sched_state_t {IDLE, INIT, INIT_W, AD, AD_W, SEND, RECV, TAG_W, DONE}.
  - typedef logic [WBLK_C-1:0] blk_t.
- One sub-module, ascon_blk_slicer: purely combinational, selects block[cnt] from the wave register using the MSB-first rule. It is reused by the UART FSM for cipher transmission.

Test Plan:
1. Nominal: wave = blocks 0x0000_0000_0000_0000..0x0000_0000_0000_0016, core model returns cph = blk XOR 0xFFFF_FFFF_FFFF_FFFF with 2-cycle latency -> 23 handshakes, blk_last_o only on block 22, cipher_o slot k = ~k, done_o exactly 1 cycle after tag_valid_i.
2. Backpressure: hold blk_ready_i=0 for 5 cycles on block 7 -> blk_o stays 0x...07 with blk_valid_o=1 throughout; no cph write until accepted.
3. Start during busy: pulse start_i with a different wave at block 10 -> ignored; final cipher_o matches the first wave only.
4. Reset mid-op: assert reset_i during RECV of block 12 -> next cycle state IDLE, busy_o=0, cipher_o=0, counter=0; a fresh start then completes normally.
5. Spurious strobes: cph_valid_i in INIT_W and tag_valid_i in SEND -> no state change, no cipher_o write.
6. (ASCON_SCHED_TIMEOUT_EN, TIMEOUT=16) withhold ad_done_i -> err_o=1 at cycle 16 of AD_W, busy_o=0, no done_o; next start clears err_o.
